// File: rtl/uart_reporter_pkg.sv
// Shared types and constants for the UART result reporter and its byte serializer.
package uart_reporter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StSend,
    StWaitB,
    StDone
  } reporter_state_t;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } uart_tx_state_t;

  localparam logic [7:0] UART_HDR0 = 8'hA5;
  localparam logic [7:0] UART_HDR1 = 8'h5A;

endpackage

// File: rtl/uart_tx.sv
// 8N1 byte serializer; accepts a byte via valid/ready only while idle.
module uart_tx
  import uart_reporter_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_serial
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

  uart_tx_state_t  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            line_q, line_d;
  logic            baud_end;

  assign baud_end  = (cnt_q == CntW'(CLKS_PER_BIT - 1));
  assign tx_ready  = (state_q == TxIdle);
  assign tx_serial = line_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      TxIdle: begin
        if (tx_valid) begin
          shift_d = tx_data;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = TxStart;
        end
      end
      TxStart: begin
        cnt_d = baud_end ? '0 : cnt_q + 1'b1;
        if (baud_end) state_d = TxData;
      end
      TxData: begin
        cnt_d = baud_end ? '0 : cnt_q + 1'b1;
        if (baud_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = TxStop;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      TxStop: begin
        cnt_d = baud_end ? '0 : cnt_q + 1'b1;
        if (baud_end) state_d = TxIdle;
      end
      default: state_d = TxIdle;
    endcase
    // Line is registered from the current state, so every bit is delayed uniformly by one cycle.
    line_d = 1'b1;
    if (state_q == TxStart)     line_d = 1'b0;
    else if (state_q == TxData) line_d = shift_q[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: rtl/uart_reporter.sv
// Dumps NUM_WORDS 32-bit words over UART, little-endian, address 0 upward.
// Define UART_REPORT_HEADER_EN to prefix each dump with A5 5A NUM_WORDS[7:0].
module uart_reporter
  import uart_reporter_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned NUM_WORDS    = 32,
  parameter int unsigned ADDR_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              tx_serial,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_WORDS - 1);

  reporter_state_t   state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              tx_valid, tx_ready;
  logic [7:0]        tx_data;
`ifdef UART_REPORT_HEADER_EN
  localparam logic [7:0] NumWordsByte = 8'(NUM_WORDS);
  logic hdr_q, hdr_d;
`endif

  assign rd_addr = addr_q;
  assign busy    = busy_q;
  assign done    = (state_q == StDone);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    word_d   = word_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    tx_valid = 1'b0;
    tx_data  = word_q[7:0];
`ifdef UART_REPORT_HEADER_EN
    hdr_d = hdr_q;
    if (hdr_q) begin
      unique case (idx_q)
        2'd0:    tx_data = UART_HDR0;
        2'd1:    tx_data = UART_HDR1;
        default: tx_data = NumWordsByte;
      endcase
    end
`endif
    unique case (state_q)
      StIdle: begin
        if (dump_start) begin
          busy_d  = 1'b1;
          state_d = StFetch;
`ifdef UART_REPORT_HEADER_EN
          hdr_d = 1'b1;
`endif
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        word_d  = rd_data;
        idx_d   = '0;
        state_d = StSend;
      end
      StSend: begin
        tx_valid = 1'b1;
        if (tx_ready) state_d = StWaitB;
      end
      StWaitB: begin
        if (tx_ready) begin
`ifdef UART_REPORT_HEADER_EN
          // Word 0 is already latched, so the header drains straight into its first byte.
          if (hdr_q) begin
            state_d = StSend;
            if (idx_q == 2'd2) begin
              hdr_d = 1'b0;
              idx_d = '0;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else
`endif
          if (idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            word_d  = word_q >> 8;
            state_d = StSend;
          end else if (addr_q != LastAddr) begin
            addr_d  = addr_q + 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        addr_d  = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
`ifdef UART_REPORT_HEADER_EN
      hdr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
`ifdef UART_REPORT_HEADER_EN
      hdr_q <= hdr_d;
`endif
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_serial(tx_serial)
  );

endmodule

// File: tb/tb_uart_reporter.sv
// Bench for uart_reporter: a 2-word and a 1-word instance, a bit-exact UART receiver and directed vectors.
module tb_uart_reporter;

  localparam int Cpb = 4;
`ifdef UART_REPORT_HEADER_EN
  localparam int HdrN = 3;
`else
  localparam int HdrN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        dump_start;
  logic        rx_sel;
  logic [4:0]  rd_addr0, rd_addr1;
  logic [31:0] rd_data0, rd_data1;
  logic        tx0, tx1, busy0, busy1, done0, done1;
  logic [31:0] mem [32];

  wire ds0     = dump_start & ~rx_sel;
  wire ds1     = dump_start & rx_sel;
  wire rx_line = rx_sel ? tx1 : tx0;
  wire busy_m  = rx_sel ? busy1 : busy0;
  wire done_m  = rx_sel ? done1 : done0;

  always #5 clk = ~clk;

  uart_reporter #(.CLKS_PER_BIT(Cpb), .NUM_WORDS(2), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .dump_start(ds0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .tx_serial(tx0), .busy(busy0), .done(done0)
  );

  uart_reporter #(.CLKS_PER_BIT(Cpb), .NUM_WORDS(1), .ADDR_W(5)) dut1 (
    .clk(clk), .rst(rst), .dump_start(ds1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .tx_serial(tx1), .busy(busy1), .done(done1)
  );

  always @(posedge clk) begin
    rd_data0 <= mem[rd_addr0];
    rd_data1 <= mem[rd_addr1];
  end

  int total = 0;
  int bad = 0;
  int busy_cyc, done_cnt, shape_err;
  bit addr1_bad;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Receiver: every one of the Cpb samples of each bit must agree, and the stop bit must be 1.
  logic [9:0] rx_bits;
  bit         rx_ok;
  initial begin
    forever begin
      @(negedge clk);
      if (rx_line === 1'b0 && rst === 1'b0) begin
        rx_ok      = 1'b1;
        rx_bits[0] = 1'b0;
        for (int s = 1; s < Cpb; s++) begin
          @(negedge clk);
          if (rx_line !== 1'b0) rx_ok = 1'b0;
        end
        for (int b = 1; b < 10; b++) begin
          @(negedge clk);
          rx_bits[b] = rx_line;
          for (int s = 1; s < Cpb; s++) begin
            @(negedge clk);
            if (rx_line !== rx_bits[b]) rx_ok = 1'b0;
          end
        end
        if (!rx_ok || rx_bits[9] !== 1'b1) shape_err++;
        rx_q.push_back(rx_bits[8:1]);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (busy_m === 1'b1) busy_cyc++;
      if (done_m === 1'b1) done_cnt++;
      if (rd_addr1 !== 5'd0) addr1_bad = 1'b1;
    end
  end

  // mode 0: plain; 1: extra dump_start during byte 3; 2: dump_start in the done cycle.
  task automatic run_dump(input int mode, output int lat, output logic busy_early,
                          output bit timeout);
    bit poked = 0;
    bit done_seen = 0;
    int cyc = 0;
    busy_cyc  = 0;
    done_cnt  = 0;
    shape_err = 0;
    rx_q.delete();
    @(negedge clk);
    dump_start = 1'b1;
    @(posedge clk);
    #1;
    dump_start = 1'b0;
    busy_early = busy_m;
    lat = 0;
    while (rx_line !== 1'b0 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    while (cyc < 1000) begin
      @(negedge clk);
      cyc++;
      dump_start = 1'b0;
      if (done_m === 1'b1) done_seen = 1;
      if (mode == 1 && !poked && rx_q.size() == 2 && rx_line === 1'b0) begin
        dump_start = 1'b1;
        poked = 1;
      end
      if (mode == 2 && !poked && done_m === 1'b1) begin
        dump_start = 1'b1;
        poked = 1;
      end
      if (done_seen && busy_m === 1'b0 && !dump_start) break;
    end
    timeout = (cyc >= 1000);
    dump_start = 1'b0;
    repeat (60) @(negedge clk);
  endtask

  task automatic build_exp(input logic [63:0] e, input int nbytes, input logic [7:0] nw);
    exp_q.delete();
`ifdef UART_REPORT_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(nw);
`else
    if (nw == 8'hFF) exp_q.push_back(nw);  // never taken; keeps nw referenced
`endif
    for (int k = 0; k < nbytes; k++) exp_q.push_back(e[63-8*k -: 8]);
  endtask

  task automatic check_run(input string tag, input int lat, input logic busy_early,
                           input bit timeout, input int bound);
    logic [7:0] got;
    check({tag, "_timeout"}, 64'(timeout), 64'd0);
    check({tag, "_latency"}, 64'(lat), 64'd4);
    check({tag, "_busy_early"}, 64'(busy_early), 64'd1);
    check({tag, "_nbytes"}, 64'(rx_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, k), 64'(got), 64'(exp_q[k]));
    end
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_shape_err"}, 64'(shape_err), 64'd0);
    check({tag, "_busy_len_ok"}, 64'(busy_cyc <= bound), 64'd1);
    check({tag, "_busy_after"}, 64'(busy_m), 64'd0);
  endtask

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [63:0] exp;  // bytes in line order, first byte in [63:56]
  } vec_t;

  vec_t vecs[3];
  int   lat;
  logic busy_early;
  bit   timeout;
  int   cyc;
  int   bound2;

  initial begin
    vecs[0] = '{32'h12345678, 32'hDEADBEEF, 64'h78_56_34_12_EF_BE_AD_DE};
    vecs[1] = '{32'h00000000, 32'hFFFFFFFF, 64'h00_00_00_00_FF_FF_FF_FF};
    vecs[2] = '{32'hA5015AC3, 32'h80000001, 64'hC3_5A_01_A5_01_00_00_80};
    bound2 = (8 + HdrN) * (10 * Cpb + 2) + 6;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    rst = 1'b1;
    dump_start = 1'b0;
    rx_sel = 1'b0;
    addr1_bad = 1'b0;
    #3;
    check("reset_tx", 64'(tx0), 64'd1);
    check("reset_busy", 64'(busy0), 64'd0);
    check("reset_done", 64'(done0), 64'd0);
    check("reset_rd_addr", 64'(rd_addr0), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      mem[0] = vecs[i].w0;
      mem[1] = vecs[i].w1;
      build_exp(vecs[i].exp, 8, 8'h02);
      run_dump(0, lat, busy_early, timeout);
      check_run($sformatf("vec%0d", i), lat, busy_early, timeout, bound2);
    end

    mem[0] = vecs[0].w0;
    mem[1] = vecs[0].w1;
    build_exp(vecs[0].exp, 8, 8'h02);
    run_dump(1, lat, busy_early, timeout);
    check_run("ignore_busy", lat, busy_early, timeout, bound2);
    run_dump(2, lat, busy_early, timeout);
    check_run("start_on_done", lat, busy_early, timeout, bound2);

    rx_sel = 1'b1;
    mem[0] = 32'hCAFEF00D;
    mem[1] = 32'h11223344;
    addr1_bad = 1'b0;
    repeat (2) @(negedge clk);
    build_exp(64'h0D_F0_FE_CA_00_00_00_00, 4, 8'h01);
    run_dump(0, lat, busy_early, timeout);
    check_run("one_word", lat, busy_early, timeout, (4 + HdrN) * (10 * Cpb + 2) + 6);
    check("one_word_addr_max", 64'(addr1_bad), 64'd0);

    // Abort mid-byte while word 1 is on the line.
    rx_sel = 1'b0;
    rx_q.delete();
    @(negedge clk);
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    cyc = 0;
    while (!(rx_q.size() >= 4 + HdrN + 1 && tx0 === 1'b0) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached", 64'(cyc < 1000), 64'd1);
    check("abort_pre_busy", 64'(busy0), 64'd1);
    check("abort_pre_addr", 64'(rd_addr0), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_tx", 64'(tx0), 64'd1);
    check("abort_busy", 64'(busy0), 64'd0);
    check("abort_done", 64'(done0), 64'd0);
    check("abort_rd_addr", 64'(rd_addr0), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
